snake_head_ctrl: RTL

Generates the snake head position, the one-cycle move strobe and the score consumed by the snake body/renderer block. Runs a game-tick divider, accepts direction buttons with reversal rejection, and detects wall hits and food hits. Game state is IDLE/RUN/DEAD. It sits between the board inputs (debounced buttons, food generator) and the body renderer.

---
 rtl/snake_head_ctrl.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/snake_head_ctrl.sv
// Snake head controller: game-tick divider, direction capture with reversal rejection,
// wall/food detection and IDLE/RUN/DEAD state. Optional macro SNAKE_WRAP_EN: wrap-around edges plus a kill input.
module snake_head_ctrl #(
  parameter int SEG_SIZE = 20,
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480,
  parameter int TICK_DIV = 5000000,
  parameter int START_X  = 320,
  parameter int START_Y  = 240
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        start,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
`ifdef SNAKE_WRAP_EN
  input  logic        kill,
`endif
  input  logic [11:0] food_x,
  input  logic [11:0] food_y,
  output logic [11:0] head_x,
  output logic [11:0] head_y,
  output logic        move_signal,
  output logic        food_eaten,
  output logic [7:0]  score,
  output logic [1:0]  dir,
  output logic [1:0]  game_state
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [11:0] SEG     = 12'(SEG_SIZE);
  localparam logic [11:0] X_LAST  = 12'(SCREEN_W - SEG_SIZE);
  localparam logic [11:0] Y_LAST  = 12'(SCREEN_H - SEG_SIZE);
  localparam logic [11:0] X_START = 12'(START_X);
  localparam logic [11:0] Y_START = 12'(START_Y);

  localparam logic [1:0] D_UP    = 2'b00;
  localparam logic [1:0] D_DOWN  = 2'b01;
  localparam logic [1:0] D_LEFT  = 2'b10;
  localparam logic [1:0] D_RIGHT = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DEAD = 2'b10
  } state_t;

  state_t           state_reg, state_next;
  logic [11:0]      head_x_reg, head_x_next;
  logic [11:0]      head_y_reg, head_y_next;
  logic [1:0]       dir_reg, dir_next;
  logic [1:0]       pend_reg, pend_next;
  logic [7:0]       score_reg, score_next;
  logic [CNT_W-1:0] tick_reg, tick_next;
  logic             move_reg, move_next;
  logic             eaten_reg, eaten_next;

  logic       req_valid;
  logic [1:0] req;
  logic       opposite;
  logic       step;
  logic       wall;
  logic [11:0] cand_x, cand_y;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_reg  <= S_IDLE;
      head_x_reg <= X_START;
      head_y_reg <= Y_START;
      dir_reg    <= D_RIGHT;
      pend_reg   <= D_RIGHT;
      score_reg  <= 8'd0;
      tick_reg   <= '0;
      move_reg   <= 1'b0;
      eaten_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      head_x_reg <= head_x_next;
      head_y_reg <= head_y_next;
      dir_reg    <= dir_next;
      pend_reg   <= pend_next;
      score_reg  <= score_next;
      tick_reg   <= tick_next;
      move_reg   <= move_next;
      eaten_reg  <= eaten_next;
    end
  end

  // Candidate cell along the pending direction, plus the wall test on the current head.
  always_comb begin
    cand_x = head_x_reg;
    cand_y = head_y_reg;
    wall   = 1'b0;
    case (pend_reg)
      D_UP: begin
        cand_y = head_y_reg - SEG;
        wall   = (head_y_reg == 12'd0);
`ifdef SNAKE_WRAP_EN
        if (wall) cand_y = Y_LAST;
`endif
      end
      D_DOWN: begin
        cand_y = head_y_reg + SEG;
        wall   = (head_y_reg >= Y_LAST);
`ifdef SNAKE_WRAP_EN
        if (wall) cand_y = 12'd0;
`endif
      end
      D_LEFT: begin
        cand_x = head_x_reg - SEG;
        wall   = (head_x_reg == 12'd0);
`ifdef SNAKE_WRAP_EN
        if (wall) cand_x = X_LAST;
`endif
      end
      default: begin
        cand_x = head_x_reg + SEG;
        wall   = (head_x_reg >= X_LAST);
`ifdef SNAKE_WRAP_EN
        if (wall) cand_x = 12'd0;
`endif
      end
    endcase
`ifdef SNAKE_WRAP_EN
    wall = 1'b0;
`endif
  end

  always_comb begin
    state_next  = state_reg;
    head_x_next = head_x_reg;
    head_y_next = head_y_reg;
    dir_next    = dir_reg;
    pend_next   = pend_reg;
    score_next  = score_reg;
    tick_next   = tick_reg;
    move_next   = 1'b0;
    eaten_next  = 1'b0;

    req_valid = btn_up | btn_down | btn_left | btn_right;
    req = btn_up ? D_UP : btn_down ? D_DOWN : btn_left ? D_LEFT : D_RIGHT;
    // Opposite pairs differ only in bit 0 of the encoding.
    opposite = ({req[1], ~req[0]} == dir_reg);
    step = (state_reg == S_RUN) && (tick_reg == TICK_LAST);

    case (state_reg)
      S_IDLE: begin
        tick_next = '0;
        if (start) state_next = S_RUN;
      end
      S_RUN: begin
        tick_next = step ? '0 : tick_reg + 1'b1;
        if (req_valid && !opposite) pend_next = req;
`ifdef SNAKE_WRAP_EN
        if (kill) begin
          state_next = S_DEAD;
        end else
`endif
        if (step) begin
          if (wall) begin
            state_next = S_DEAD;
          end else begin
            head_x_next = cand_x;
            head_y_next = cand_y;
            dir_next    = pend_reg;
            move_next   = 1'b1;
            if (cand_x == food_x && cand_y == food_y) begin
              eaten_next = 1'b1;
              score_next = (score_reg == 8'hFF) ? 8'hFF : score_reg + 8'd1;
            end
          end
        end
      end
      S_DEAD: begin
        if (start) begin
          state_next  = S_IDLE;
          head_x_next = X_START;
          head_y_next = Y_START;
          dir_next    = D_RIGHT;
          pend_next   = D_RIGHT;
          score_next  = 8'd0;
          tick_next   = '0;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign head_x      = head_x_reg;
  assign head_y      = head_y_reg;
  assign move_signal = move_reg;
  assign food_eaten  = eaten_reg;
  assign score       = score_reg;
  assign dir         = dir_reg;
  assign game_state  = state_reg;

endmodule
